// File: rtl/ser2para_rx.sv
// Serial display link receiver: oversamples {SEGCLK,SEGCLR,SEGDT,SEGEN} and
// rebuilds each MSB-first WIDTH-bit frame into a parallel word with a valid strobe.
module ser2para_rx #(
    parameter int WIDTH       = 24,
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       sin,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             frame_err,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LIMIT = GW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t                       state_q, state_d;
    logic [SYNC_STAGES-1:0][3:0]  sync_q, sync_d;
    logic                         sclk_prev_q, sclk_prev_d;
    logic [CW-1:0]                bitcnt_q, bitcnt_d;
    logic [GW-1:0]                gap_q, gap_d;
    logic [WIDTH-1:0]             sreg_q, sreg_d;
    logic [WIDTH-1:0]             data_q, data_d;
    logic                         valid_q, valid_d;
    logic                         frame_err_q, frame_err_d;

    logic [3:0]       sync_out;
    logic             sclk_sync, clr_sync, dt_sync, en_sync;
    logic             sclk_rise, qual_bit;
    logic [WIDTH-1:0] shifted;

    // All four lines share one synchronizer so SEGDT lines up with the SEGCLK edge.
    assign sync_out    = sync_q[SYNC_STAGES-1];
    assign sclk_sync   = sync_out[3];
    assign clr_sync    = sync_out[2];
    assign dt_sync     = sync_out[1];
    assign en_sync     = sync_out[0];
    assign sclk_rise   = sclk_sync & ~sclk_prev_q;
    assign qual_bit    = sclk_rise & en_sync & clr_sync;
    assign shifted     = {sreg_q[WIDTH-2:0], dt_sync};
    assign sync_d      = {sync_q[SYNC_STAGES-2:0], sin};
    assign sclk_prev_d = sclk_sync;

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        gap_d       = gap_q;
        sreg_d      = sreg_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        if (!clr_sync) begin
            state_d  = IDLE;
            bitcnt_d = '0;
            gap_d    = '0;
            sreg_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (qual_bit) begin
                        sreg_d   = shifted;
                        bitcnt_d = CW'(1);
                        gap_d    = '0;
                        state_d  = RECV;
                    end
                end
                RECV: begin
                    if (qual_bit) begin
                        gap_d = '0;
                        if (bitcnt_q == LAST_BIT) begin
                            data_d   = shifted;
                            valid_d  = 1'b1;
                            bitcnt_d = '0;
                            sreg_d   = '0;
                            state_d  = IDLE;
                        end else begin
                            sreg_d   = shifted;
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end else if (gap_q >= GAP_LIMIT) begin
                        // Link went quiet mid-frame: drop the partial word, keep data.
                        frame_err_d = 1'b1;
                        bitcnt_d    = '0;
                        gap_d       = '0;
                        sreg_d      = '0;
                        state_d     = IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            sclk_prev_q <= 1'b0;
            bitcnt_q    <= '0;
            gap_q       <= '0;
            sreg_q      <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            sclk_prev_q <= sclk_prev_d;
            bitcnt_q    <= bitcnt_d;
            gap_q       <= gap_d;
            sreg_q      <= sreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == RECV);

endmodule

// File: tb/tb_ser2para_rx.sv
// Self-checking bench for ser2para_rx: directed table, hand-written corner
// sequences and randomized link traffic checked against a bit-queue model.
module tb_ser2para_rx;
    localparam int WIDTH       = 24;
    localparam int TIMEOUT     = 64;
    localparam int SYNC_STAGES = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk_p = 1'b0, clr_p = 1'b1, dt_p = 1'b0, en_p = 1'b1;
    logic [3:0]       sin;
    logic [WIDTH-1:0] data;
    logic             valid, frame_err, busy;

    assign sin = {sclk_p, clr_p, dt_p, en_p};

    ser2para_rx #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int valid_cnt = 0, ferr_cnt = 0, valid_cyc = 0, ferr_cyc = 0, last_rise_cyc = 0;
    int m_frames = 0, m_errs = 0;
    logic [WIDTH-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference model: works on the pin-level waveform, collecting qualified
    // bits into a queue and counting idle cycles since the last one.
    initial begin : model
        logic prev;
        logic rise;
        int   gap;
        bit   active;
        bit   bits[$];
        logic [WIDTH-1:0] word;
        prev = 1'b0; gap = 0; active = 0; word = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                prev = 1'b0; gap = 0; active = 0; bits.delete();
                m_frames -= exp_q.size();
                exp_q.delete();
            end else begin
                rise = sclk_p & ~prev;
                prev = sclk_p;
                if (!clr_p) begin
                    bits.delete(); active = 0; gap = 0;
                end else if (rise && en_p) begin
                    bits.push_back(dt_p);
                    gap = 0; active = 1;
                    if (bits.size() == WIDTH) begin
                        for (int i = 0; i < WIDTH; i++) word[WIDTH-1-i] = bits[i];
                        exp_q.push_back(word);
                        m_frames++;
                        bits.delete(); active = 0;
                    end
                end else if (active) begin
                    gap++;
                    if (gap == TIMEOUT) begin
                        m_errs++;
                        bits.delete(); active = 0; gap = 0;
                    end
                end
            end
        end
    end

    // Output monitor: one line per received frame, scoreboard against the model.
    initial begin : monitor
        logic [WIDTH-1:0] last_data;
        logic [WIDTH-1:0] e;
        last_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_data = '0;
            end else begin
                if (valid && frame_err) check("valid_with_frame_err", 1, 0);
                if (valid) begin
                    valid_cnt++;
                    valid_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_data", data, e);
                        $display("frame %0d: data=%06h expected=%06h", valid_cnt, data, e);
                    end
                    last_data = data;
                end else begin
                    check("data_stable", data, last_data);
                end
                if (frame_err) begin
                    ferr_cnt++;
                    ferr_cyc = cyc;
                    $display("frame_err pulse at cycle %0d", cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sclk_p = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b, input int half, input logic en);
        @(negedge clk);
        sclk_p = 1'b0; dt_p = b; en_p = en; clr_p = 1'b1;
        tick(half - 1);
        @(negedge clk);
        sclk_p = 1'b1;
        last_rise_cyc = cyc;
        tick(half - 1);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input int half);
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i], half, 1'b1);
    endtask

    task automatic wait_valid(input int target);
        int k;
        k = 0;
        while (valid_cnt < target && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        sclk_p = 1'b0; clr_p = 1'b0;
        tick(4);
        clr_p = 1'b1;
        idle(4);
    endtask

    typedef struct {
        logic [WIDTH-1:0] word;
        int               half;
        logic [WIDTH-1:0] exp_data;
    } vec_t;

    initial begin : stim
        vec_t vecs[5];
        int v0, e0;
        logic [WIDTH-1:0] d0, w;
        int half;

        vecs[0] = '{24'hFFFFFF, 4, 24'hFFFFFF};
        vecs[1] = '{24'h000001, 4, 24'h000001};
        vecs[2] = '{24'hA5C3E1, 2, 24'hA5C3E1};
        vecs[3] = '{24'h800000, 3, 24'h800000};
        vecs[4] = '{24'h3C3C3C, 5, 24'h3C3C3C};

        // Reset state
        #12;
        check("reset_data", data, 0);
        check("reset_valid", valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        // First frame with busy and latency checks
        v0 = valid_cnt; e0 = ferr_cnt;
        w = 24'h123456;
        send_bit(w[WIDTH-1], 4, 1'b1);
        check("t1_busy_after_first_bit", busy, 1);
        for (int i = WIDTH - 2; i >= 0; i--) send_bit(w[i], 4, 1'b1);
        wait_valid(v0 + 1);
        check("t1_valid_count", valid_cnt - v0, 1);
        check("t1_data", data, 24'h123456);
        check("t1_latency", valid_cyc - last_rise_cyc, SYNC_STAGES + 1);
        tick(1);
        check("t1_busy_after_valid", busy, 0);
        check("t1_no_frame_err", ferr_cnt - e0, 0);

        // Back-to-back table frames
        for (int t = 0; t < 5; t++) begin
            v0 = valid_cnt;
            send_frame(vecs[t].word, vecs[t].half);
            wait_valid(v0 + 1);
            check($sformatf("tab%0d_valid", t), valid_cnt - v0, 1);
            check($sformatf("tab%0d_data", t), data, vecs[t].exp_data);
        end
        idle(4);

        // Partial frame timeout
        v0 = valid_cnt; e0 = ferr_cnt; d0 = data;
        w = 24'h9E3779;
        for (int i = 0; i < 10; i++) send_bit(w[WIDTH-1-i], 4, 1'b1);
        idle(100);
        check("to_frame_err_count", ferr_cnt - e0, 1);
        check("to_frame_err_time", ferr_cyc - last_rise_cyc, TIMEOUT + SYNC_STAGES + 1);
        check("to_busy", busy, 0);
        check("to_data_held", data, d0);
        check("to_no_valid", valid_cnt - v0, 0);
        send_frame(24'hABCDEF, 4);
        wait_valid(v0 + 1);
        check("to_next_data", data, 24'hABCDEF);
        idle(4);

        // SEGEN low on bits 4-7, then resent with SEGEN high
        v0 = valid_cnt;
        w = 24'h0F0F0F;
        for (int i = 0; i < 4; i++) send_bit(w[WIDTH-1-i], 4, 1'b1);
        for (int i = 4; i < 8; i++) send_bit(~w[WIDTH-1-i], 4, 1'b0);
        for (int i = 4; i < WIDTH; i++) send_bit(w[WIDTH-1-i], 4, 1'b1);
        wait_valid(v0 + 1);
        check("en_valid", valid_cnt - v0, 1);
        check("en_data", data, 24'h0F0F0F);
        idle(4);

        // SEGCLR abort after 12 bits
        v0 = valid_cnt; e0 = ferr_cnt;
        w = 24'hC3C3C3;
        for (int i = 0; i < 12; i++) send_bit(w[WIDTH-1-i], 4, 1'b1);
        clr_pulse();
        check("clr_busy", busy, 0);
        send_frame(24'h5A5A5A, 4);
        wait_valid(v0 + 1);
        idle(TIMEOUT + 10);
        check("clr_valid", valid_cnt - v0, 1);
        check("clr_data", data, 24'h5A5A5A);
        check("clr_no_frame_err", ferr_cnt - e0, 0);

        // Asynchronous reset mid-frame
        e0 = ferr_cnt;
        w = 24'h777777;
        for (int i = 0; i < 15; i++) send_bit(w[WIDTH-1-i], 4, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_data", data, 0);
        check("arst_valid", valid, 0);
        check("arst_frame_err", frame_err, 0);
        check("arst_busy", busy, 0);
        idle(3);
        rst_n = 1'b1;
        idle(3);
        v0 = valid_cnt;
        send_frame(24'h777777, 4);
        wait_valid(v0 + 1);
        check("arst_next_data", data, 24'h777777);
        check("arst_no_frame_err", ferr_cnt - e0, 0);
        idle(4);

        // Randomized traffic: ignored edges, stalls around the timeout, clears
        for (int f = 0; f < 120; f++) begin
            w = WIDTH'($urandom);
            half = int'($urandom_range(2, 5));
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if ($urandom_range(0, 19) == 0) send_bit(1'($urandom_range(0, 1)), half, 1'b0);
                if ($urandom_range(0, 99) == 0)
                    idle(TIMEOUT - 2 * half - 2 + int'($urandom_range(0, 4)));
                if ($urandom_range(0, 299) == 0) clr_pulse();
                send_bit(w[i], half, 1'b1);
            end
            idle(int'($urandom_range(0, 4)));
        end
        idle(TIMEOUT + 10);

        check("total_frames", valid_cnt, m_frames);
        check("total_frame_errs", ferr_cnt, m_errs);
        check("pending_frames", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
